// File: rtl/display_timing_gen.sv
// Display raster timing generator: free-running column/line counters with
// registered, mutually aligned sync, blanking and frame-start outputs.
module display_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        pClk,
  input  logic        pReset,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic [10:0] pixel_row,
  output logic [10:0] pixel_column,
  output logic        frame_start
);

  localparam int unsigned CW           = 11;
  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Position that the output registers will present on the next edge.
  // The counters run one step ahead of the outputs so every output is a
  // registered decode of the same position.
  logic [CW-1:0] hCnt;
  logic [CW-1:0] vCnt;

  logic hLastC;
  logic vLastC;
  logic hSyncC;
  logic vSyncC;
  logic videoOnC;
  logic frameStartC;

  // Wrap detection and position decode for the upcoming output position.
  always_comb begin
    hLastC      = (hCnt == CW'(H_TOTAL - 1));
    vLastC      = (vCnt == CW'(V_TOTAL - 1));
    hSyncC      = (hCnt >= CW'(H_SYNC_START)) && (hCnt < CW'(H_SYNC_END));
    vSyncC      = (vCnt >= CW'(V_SYNC_START)) && (vCnt < CW'(V_SYNC_END));
    videoOnC    = (hCnt < CW'(H_ACTIVE)) && (vCnt < CW'(V_ACTIVE));
    frameStartC = (hCnt == '0) && (vCnt == '0);
  end

  // Horizontal counter every clock; vertical counter on horizontal wrap.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hLastC) begin
      hCnt <= '0;
      vCnt <= vLastC ? '0 : vCnt + CW'(1);
    end else begin
      hCnt <= hCnt + CW'(1);
    end
  end

  // Output registers; reset forces inactive syncs so no partial pulse survives.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      pixel_column <= '0;
      pixel_row    <= '0;
      horiz_sync   <= ~SYNC_POL;
      vert_sync    <= ~SYNC_POL;
      video_on     <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      pixel_column <= hCnt;
      pixel_row    <= vCnt;
      horiz_sync   <= hSyncC ? SYNC_POL : ~SYNC_POL;
      vert_sync    <= vSyncC ? SYNC_POL : ~SYNC_POL;
      video_on     <= videoOnC;
      frame_start  <= frameStartC;
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Self-checking bench for display_timing_gen: two small-raster instances
// (both sync polarities) plus one default-raster instance, checked against
// a position model derived from the elapsed clock count.
module tb_display_timing_gen;

  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
  localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFT = SHT * SVT;

  typedef struct packed {
    logic [10:0] col;
    logic [10:0] row;
    logic        hs;
    logic        vs;
    logic        von;
    logic        fs;
  } obs_t;

  typedef struct {
    bit   rst;
    obs_t want;
  } vec_t;

  logic pClk = 1'b0;
  logic pReset = 1'b1;

  logic sHs, sVs, sVon, sFs;  logic [10:0] sRow, sCol;
  logic pHs, pVs, pVon, pFs;  logic [10:0] pRow, pCol;
  logic dHs, dVs, dVon, dFs;  logic [10:0] dRow, dCol;

  obs_t gotS, gotP, gotD;
  assign gotS = {sCol, sRow, sHs, sVs, sVon, sFs};
  assign gotP = {pCol, pRow, pHs, pVs, pVon, pFs};
  assign gotD = {dCol, dRow, dHs, dVs, dVon, dFs};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 pClk = ~pClk;

  display_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)) dutS (
    .pClk(pClk), .pReset(pReset), .horiz_sync(sHs), .vert_sync(sVs),
    .video_on(sVon), .pixel_row(sRow), .pixel_column(sCol), .frame_start(sFs));

  display_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)) dutP (
    .pClk(pClk), .pReset(pReset), .horiz_sync(pHs), .vert_sync(pVs),
    .video_on(pVon), .pixel_row(pRow), .pixel_column(pCol), .frame_start(pFs));

  display_timing_gen dutD (
    .pClk(pClk), .pReset(pReset), .horiz_sync(dHs), .vert_sync(dVs),
    .video_on(dVon), .pixel_row(dRow), .pixel_column(dCol), .frame_start(dFs));

  function automatic obs_t mk(int col, int row, bit hs, bit vs, bit von, bit fs);
    obs_t o;
    o.col = 11'(col); o.row = 11'(row);
    o.hs = hs; o.vs = vs; o.von = von; o.fs = fs;
    return o;
  endfunction

  // Position = clocks since reset release modulo frame size; flags from the raster rules.
  function automatic obs_t refPos(int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb,
                                  bit pol, bit inRst, int c);
    int ht, vt, p, x, y;
    bit hAct, vAct;
    if (inRst) return mk(0, 0, ~pol, ~pol, 1'b0, 1'b0);
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p = c % (ht * vt);
    x = p % ht;
    y = p / ht;
    hAct = (x >= ha + hf) && (x < ha + hf + hsw);
    vAct = (y >= va + vf) && (y < va + vf + vsw);
    return mk(x, y, hAct ? pol : ~pol, vAct ? pol : ~pol,
              (x < ha) && (y < va), p == 0);
  endfunction

  task automatic cmp(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got col=%0d row=%0d hs=%b vs=%b von=%b fs=%b want col=%0d row=%0d hs=%b vs=%b von=%b fs=%b",
               name, $time, got.col, got.row, got.hs, got.vs, got.von, got.fs,
               want.col, want.row, want.hs, want.vs, want.von, want.fs);
    end
  endtask

  task automatic cmpInt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One clock with the given reset value; all three instances checked against the model.
  task automatic step(input bit r);
    obs_t eS, eP, eD;
    int c;
    pReset = r;
    @(posedge pClk);
    #1;
    c = cyc;
    eS = refPos(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, r, c);
    eP = refPos(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, r, c);
    eD = refPos(1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, r, c);
    cyc = r ? 0 : cyc + 1;
    cmp("small", gotS, eS);
    cmp("inverted", gotP, eP);
    cmp("default", gotD, eD);
  endtask

  vec_t vecs[7];

  initial begin
    int hsLow, firstLow, vonCnt, vsLow, pvsHigh, fsCnt, lastFs, gap;
    bit sawWrap, sawRise, found;
    obs_t prev;

    vecs[0] = '{1'b1, mk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[1] = '{1'b1, mk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[2] = '{1'b0, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1)};
    vecs[3] = '{1'b0, mk(1, 0, 1'b1, 1'b1, 1'b1, 1'b0)};
    vecs[4] = '{1'b0, mk(2, 0, 1'b1, 1'b1, 1'b1, 1'b0)};
    vecs[5] = '{1'b1, mk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[6] = '{1'b0, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1)};

    // Reset and release vectors.
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].rst);
      cmp("vector", gotS, vecs[i].want);
    end

    // Default raster, first full line: hsync low only on columns 1048..1183.
    step(1'b1);
    hsLow = 0; firstLow = -1;
    for (int i = 0; i <= 1344; i++) begin
      step(1'b0);
      if (dRow == 11'd0 && dHs == 1'b0) begin
        hsLow++;
        if (firstLow < 0) firstLow = int'(dCol);
      end
    end
    cmpInt("default hsync width", hsLow, 136);
    cmpInt("default hsync first column", firstLow, 1048);
    cmp("default line wrap", gotD, mk(0, 1, 1'b1, 1'b1, 1'b1, 1'b0));

    // Small raster, two frames: frame spacing, visible count, vsync width and rise, final wrap.
    step(1'b1);
    vonCnt = 0; vsLow = 0; pvsHigh = 0; fsCnt = 0; lastFs = -1; gap = -1;
    sawWrap = 1'b0; sawRise = 1'b0;
    prev = gotS;
    for (int i = 0; i < 2 * SFT + 1; i++) begin
      step(1'b0);
      if (i < SFT) begin
        if (sVon) vonCnt++;
        if (!sVs) vsLow++;
        if (pVs) pvsHigh++;
      end
      if (sFs) begin
        if (lastFs >= 0) gap = i - lastFs;
        lastFs = i;
        fsCnt++;
      end
      if (prev.col == 11'(SHT - 1) && prev.row == 11'(SVT - 1)) begin
        sawWrap = 1'b1;
        cmp("frame wrap", gotS, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1));
      end
      if (sRow == 11'(SVA + SVF + SVS) && sCol == 11'd0) begin
        sawRise = 1'b1;
        cmpInt("vsync rise", {31'd0, prev.vs, 1'b0} | {31'd0, 1'b0, sVs}, 1);
      end
      prev = gotS;
    end
    cmpInt("frame_start count", fsCnt, 3);
    cmpInt("frame_start spacing", gap, SFT);
    cmpInt("video_on per frame", vonCnt, SHA * SVA);
    cmpInt("vsync low clocks", vsLow, SVS * SHT);
    cmpInt("inverted vsync high clocks", pvsHigh, SVS * SHT);
    cmpInt("frame wrap reached", int'(sawWrap), 1);
    cmpInt("vsync rise reached", int'(sawRise), 1);

    // Reset while both syncs are active: no held-over pulse, then restart.
    step(1'b1);
    found = 1'b0;
    for (int i = 0; i < 2 * SFT && !found; i++) begin
      step(1'b0);
      if (sCol == 11'(SHA + SHF) && sRow == 11'(SVA + SVF)) found = 1'b1;
    end
    cmpInt("mid-sync position reached", int'(found), 1);
    cmpInt("both syncs active before reset", {30'd0, sHs, sVs}, 0);
    step(1'b1);
    cmp("mid-sync reset", gotS, mk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0));
    cmp("mid-sync reset inverted", gotP, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0);
    cmp("restart after reset", gotS, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1));

    // Random run with sporadic resets against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 24, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 136, horizontal sync width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 160, horizontal back porch in clocks; line total is H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344).
REQ-005 The block SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 3, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 29, vertical back porch in lines; frame total is 806 lines by default.
REQ-009 The block SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 pClk  input  1  pixel clock; the single clock of the block, all logic on its rising edge.
REQ-011 pReset  input  1  synchronous, active-high reset.
REQ-012 horiz_sync  output  1  horizontal sync at SYNC_POL level when active.
REQ-013 vert_sync  output  1  vertical sync at SYNC_POL level when active.
REQ-014 video_on  output  1  high when the current position is inside the visible area.
REQ-015 pixel_row  output  11  current line number, 0..total lines-1.
REQ-016 pixel_column  output  11  current column number, 0..line total-1.
REQ-017 frame_start  output  1  one-clock pulse at position (0,0).

Function
REQ-018 The block SHALL keep an 11-bit horizontal counter that increments by 1 every pClk and wraps from line total-1 to 0.
REQ-019 The block SHALL keep an 11-bit vertical counter that increments by 1 only when the horizontal counter wraps, and wraps from frame total-1 to 0 on that same cycle.
REQ-020 All outputs SHALL be registered and mutually aligned: in every cycle, horiz_sync, vert_sync, video_on and frame_start describe the position presented on pixel_row/pixel_column.
REQ-021 video_on SHALL be 1 iff pixel_column < H_ACTIVE and pixel_row < V_ACTIVE.
REQ-022 horiz_sync SHALL be active iff H_ACTIVE+H_FP <= pixel_column < H_ACTIVE+H_FP+H_SYNC (default columns 1048..1183).
REQ-023 vert_sync SHALL be active iff V_ACTIVE+V_FP <= pixel_row < V_ACTIVE+V_FP+V_SYNC (default lines 771..776), over entire lines.
REQ-024 frame_start SHALL be 1 iff pixel_row = 0 and pixel_column = 0.
REQ-025 pixel_row and pixel_column SHALL be output unmodified during blanking; downstream stages gate with video_on and decimate (for example using bits [9:3]) themselves.
REQ-026 Simultaneous horizontal and vertical wrap at (line total-1, frame total-1) SHALL produce (0,0) with frame_start = 1 on the next cycle.
REQ-027 Counters SHALL never take values at or beyond their totals; parameter totals above 2047 are unsupported.

Reset
REQ-028 While pReset = 1 on a rising edge, the block SHALL load pixel_row = 0, pixel_column = 0, video_on = 0, frame_start = 0, and both syncs at the inactive level (1 when SYNC_POL = 0).
REQ-029 On the first rising edge with pReset = 0, the outputs SHALL present position (0,0) with video_on = 1 and frame_start = 1, and advance one column per clock thereafter.
REQ-030 Reset asserted mid-frame SHALL abandon the current frame with no partial sync pulse held over, and restart per REQ-028/REQ-029.

Verification
REQ-031 Release reset, run 1344 clocks: pixel_column steps 0..1343 and returns to 0, pixel_row goes 0 to 1 on the wrap, and horiz_sync is 0 for exactly columns 1048..1183 (136 clocks).
REQ-032 Run 2 full frames: frame_start pulses exactly 1083264 clocks apart (1344*806), and video_on is high for 786432 clocks per frame.
REQ-033 Observe lines 770..777: vert_sync is 0 for exactly lines 771..776 (6*1344 = 8064 clocks) and rises at position (0,777).
REQ-034 At position (1343,805): the next cycle shows (0,0), frame_start = 1, video_on = 1, vert_sync = 1.
REQ-035 Assert pReset for 1 clock at position (1100,772), with both syncs active: the following cycle shows both syncs = 1, video_on = 0 and (0,0); the cycle after release shows (0,0) with frame_start = 1.
REQ-036 Set SYNC_POL = 1: the sync waveforms are the inverse of REQ-031 and REQ-033, and all other outputs are unchanged.
